// File: rtl/pix_align_pipe.sv
// pix_align_pipe: delays a pixel-pair word and its ZBT write address through
// independent pipelines. The data depth is fixed at build time. The address
// delay can be selected at runtime, and addr_valid is suppressed while the
// address pipe re-primes after the delay changes.
module pix_align_pipe #(
    parameter int DATA_W     = 36,
    parameter int ADDR_W     = 19,
    parameter int DATA_DELAY = 2,
    parameter int ADDR_DEPTH = 16,
    parameter int SEL_W      = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              en,
    input  logic              flush,
    input  logic [DATA_W-1:0] din,
    input  logic              din_valid,
    input  logic [ADDR_W-1:0] addr_in,
    input  logic [SEL_W-1:0]  addr_tap,
    output logic [DATA_W-1:0] dout,
    output logic              dout_valid,
    output logic [ADDR_W-1:0] addr_out,
    output logic              addr_valid,
    output logic              settling
);

    localparam int TAP_W = (ADDR_DEPTH > 1) ? $clog2(ADDR_DEPTH) : 1;
    localparam int CNT_W = $clog2(ADDR_DEPTH + 1);

    logic [DATA_W-1:0]     dat_q [DATA_DELAY];
    logic [DATA_DELAY-1:0] dvld_q;
    logic [ADDR_W-1:0]     adr_q [ADDR_DEPTH];
    logic [ADDR_DEPTH-1:0] avld_q;

    logic [TAP_W-1:0] tap_q, tap_d, tap_eff;
    logic [CNT_W-1:0] settle_cnt_q, settle_cnt_d;

    // Requested tap is clamped to the deepest address stage (unsigned compare).
    function automatic logic [TAP_W-1:0] clamp_tap(input logic [SEL_W-1:0] req);
        if (32'(req) >= 32'(ADDR_DEPTH - 1))
            return TAP_W'(ADDR_DEPTH - 1);
        else
            return TAP_W'(req);
    endfunction

    assign tap_eff = clamp_tap(addr_tap);

    // Data pipe: shift {valid, data} on enabled edges; flush only drops valids.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DATA_DELAY; i++) dat_q[i] <= '0;
            dvld_q <= '0;
        end else if (flush) begin
            dvld_q <= '0;
        end else if (en) begin
            dat_q[0]  <= din;
            dvld_q[0] <= din_valid;
            for (int i = 1; i < DATA_DELAY; i++) begin
                dat_q[i]  <= dat_q[i-1];
                dvld_q[i] <= dvld_q[i-1];
            end
        end
    end

    // Address pipe: same shifting as the data pipe, with its own depth.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < ADDR_DEPTH; i++) adr_q[i] <= '0;
            avld_q <= '0;
        end else if (flush) begin
            avld_q <= '0;
        end else if (en) begin
            adr_q[0]  <= addr_in;
            avld_q[0] <= din_valid;
            for (int i = 1; i < ADDR_DEPTH; i++) begin
                adr_q[i]  <= adr_q[i-1];
                avld_q[i] <= avld_q[i-1];
            end
        end
    end

    // Tap/settle next state. A flush zeroes the counter but still accepts a new
    // tap, because the cleared valid bits already cover the re-prime.
    always_comb begin
        tap_d        = tap_q;
        settle_cnt_d = settle_cnt_q;
        if (flush) begin
            settle_cnt_d = '0;
            if (en && (tap_eff != tap_q)) tap_d = tap_eff;
        end else if (en) begin
            if (tap_eff != tap_q) begin
                tap_d        = tap_eff;
                settle_cnt_d = CNT_W'(tap_eff) + CNT_W'(1);
            end else if (settle_cnt_q != '0) begin
                settle_cnt_d = settle_cnt_q - CNT_W'(1);
            end
        end
    end

    // Tap/settle registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            tap_q        <= '0;
            settle_cnt_q <= '0;
        end else begin
            tap_q        <= tap_d;
            settle_cnt_q <= settle_cnt_d;
        end
    end

    assign dout       = dat_q[DATA_DELAY-1];
    assign dout_valid = dvld_q[DATA_DELAY-1];
    assign settling   = (settle_cnt_q != '0);
    assign addr_out   = adr_q[tap_q];
    assign addr_valid = avld_q[tap_q] & ~settling;

endmodule

// File: tb/tb_pix_align_pipe.sv
// Bench for pix_align_pipe: a history-based reference model plus a directed
// stream with hand-computed spot checks.
module tb_pix_align_pipe;

    localparam int DATA_W     = 36;
    localparam int ADDR_W     = 19;
    localparam int DATA_DELAY = 2;
    localparam int ADDR_DEPTH = 16;
    localparam int SEL_W      = 5;

    logic              clk = 1'b0;
    logic              reset, en, flush, din_valid;
    logic [DATA_W-1:0] din;
    logic [ADDR_W-1:0] addr_in;
    logic [SEL_W-1:0]  addr_tap;
    logic [DATA_W-1:0] dout;
    logic              dout_valid, addr_valid, settling;
    logic [ADDR_W-1:0] addr_out;

    int vectors     = 0;
    int miscompares = 0;
    bit chk_en      = 1'b0;

    pix_align_pipe #(
        .DATA_W(DATA_W), .ADDR_W(ADDR_W), .DATA_DELAY(DATA_DELAY),
        .ADDR_DEPTH(ADDR_DEPTH), .SEL_W(SEL_W)
    ) dut (
        .clk(clk), .reset(reset), .en(en), .flush(flush),
        .din(din), .din_valid(din_valid), .addr_in(addr_in), .addr_tap(addr_tap),
        .dout(dout), .dout_valid(dout_valid), .addr_out(addr_out),
        .addr_valid(addr_valid), .settling(settling)
    );

    always #5 clk = ~clk;

    // Reference model: every word accepted since reset is kept in a history.
    // A stage t of either pipe holds the word accepted t edges ago. A flush
    // invalidates everything accepted before it without moving anything.
    logic [DATA_W-1:0] h_data [0:1023];
    logic [ADDR_W-1:0] h_addr [0:1023];
    bit                h_vld  [0:1023];
    int n      = 0;
    int fmark  = 0;
    int m_tap  = 0;
    int m_sett = 0;

    always @(posedge clk) begin
        int eff;
        eff = (int'(addr_tap) > ADDR_DEPTH - 1) ? ADDR_DEPTH - 1 : int'(addr_tap);
        if (reset) begin
            n = 0; fmark = 0; m_tap = 0; m_sett = 0;
        end else if (flush) begin
            fmark  = n;
            m_sett = 0;
            if (en) m_tap = eff;
        end else if (en) begin
            h_data[n] = din; h_addr[n] = addr_in; h_vld[n] = din_valid;
            n = n + 1;
            if (eff != m_tap) begin
                m_tap  = eff;
                m_sett = eff + 1;
            end else if (m_sett > 0) begin
                m_sett = m_sett - 1;
            end
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Compare every output against the model on the falling edge.
    always @(negedge clk) begin
        if (chk_en) begin
            int di, ai;
            logic [DATA_W-1:0] e_d;
            logic [ADDR_W-1:0] e_a;
            bit e_dv, e_av;
            di = n - DATA_DELAY;
            ai = n - 1 - m_tap;
            e_d  = (di >= 0) ? h_data[di] : '0;
            e_dv = (di >= 0) && h_vld[di] && (di >= fmark);
            e_a  = (ai >= 0) ? h_addr[ai] : '0;
            e_av = (ai >= 0) && h_vld[ai] && (ai >= fmark) && (m_sett == 0);
            chk("m_dout",       64'(dout),       64'(e_d));
            chk("m_dout_valid", 64'(dout_valid), 64'(e_dv));
            chk("m_addr_out",   64'(addr_out),   64'(e_a));
            chk("m_addr_valid", 64'(addr_valid), 64'(e_av));
            chk("m_settling",   64'(settling),   64'(m_sett != 0));
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input int v, input int tap);
        en = 1'b1; din_valid = 1'b1; flush = 1'b0;
        din = DATA_W'(v); addr_in = ADDR_W'(v); addr_tap = SEL_W'(tap);
        cyc();
    endtask

    initial begin
        reset = 1'b1; en = 1'b0; flush = 1'b0; din_valid = 1'b0;
        din = '0; addr_in = '0; addr_tap = '0;
        cyc();
        chk_en = 1'b1;
        cyc();
        chk("rst_dout", 64'(dout), 64'd0);
        chk("rst_dout_valid", 64'(dout_valid), 64'd0);
        chk("rst_addr_valid", 64'(addr_valid), 64'd0);
        chk("rst_settling", 64'(settling), 64'd0);

        // Prime the tap to 1 with no valid traffic.
        reset = 1'b0; en = 1'b1; addr_tap = SEL_W'(1);
        cyc();
        chk("prime_settling_hi", 64'(settling), 64'd1);
        repeat (3) cyc();
        chk("prime_settling_lo", 64'(settling), 64'd0);

        // Aligned stream with tap 1.
        for (int v = 1; v <= 8; v++) begin
            push(v, 1);
            if (v == 1) chk("s1_dout_valid", 64'(dout_valid), 64'd0);
            if (v == 2) begin
                chk("s2_dout", 64'(dout), 64'd1);
                chk("s2_addr_out", 64'(addr_out), 64'd1);
                chk("s2_dout_valid", 64'(dout_valid), 64'd1);
                chk("s2_addr_valid", 64'(addr_valid), 64'd1);
            end
        end

        // Three stalled cycles: outputs frozen on word 7.
        en = 1'b0; din = DATA_W'(99); addr_in = ADDR_W'(99);
        for (int k = 0; k < 3; k++) begin
            cyc();
            chk("stall_dout", 64'(dout), 64'd7);
            chk("stall_addr", 64'(addr_out), 64'd7);
        end

        // Resume; tap moves to 5 at word 10.
        for (int v = 9; v <= 20; v++) begin
            push(v, (v >= 10) ? 5 : 1);
            if (v == 9)  chk("resume_dout", 64'(dout), 64'd8);
            if (v == 10) begin
                chk("t5_settling_10", 64'(settling), 64'd1);
                chk("t5_addr_valid_10", 64'(addr_valid), 64'd0);
            end
            if (v == 15) chk("t5_settling_15", 64'(settling), 64'd1);
            if (v == 16) begin
                chk("t5_settling_16", 64'(settling), 64'd0);
                chk("t5_addr_valid_16", 64'(addr_valid), 64'd1);
                chk("t5_addr_out_16", 64'(addr_out), 64'd11);
                chk("t5_dout_16", 64'(dout), 64'd15);
            end
        end

        for (int v = 21; v <= 23; v++) push(v, 5);
        // One-cycle flush: valids drop, contents stay.
        flush = 1'b1; din_valid = 1'b0;
        cyc();
        flush = 1'b0;
        chk("fl_dout_valid", 64'(dout_valid), 64'd0);
        chk("fl_addr_valid", 64'(addr_valid), 64'd0);
        chk("fl_dout", 64'(dout), 64'd22);
        chk("fl_addr_out", 64'(addr_out), 64'd18);
        for (int v = 24; v <= 29; v++) begin
            push(v, 5);
            if (v == 24) chk("fl_dv_24", 64'(dout_valid), 64'd0);
            if (v == 25) begin
                chk("fl_dv_25", 64'(dout_valid), 64'd1);
                chk("fl_dout_25", 64'(dout), 64'd24);
            end
            if (v == 28) chk("fl_av_28", 64'(addr_valid), 64'd0);
            if (v == 29) begin
                chk("fl_av_29", 64'(addr_valid), 64'd1);
                chk("fl_addr_29", 64'(addr_out), 64'd24);
            end
        end

        // Oversized tap is clamped to the deepest stage.
        for (int v = 30; v <= 48; v++) begin
            push(v, 20);
            if (v == 45) chk("clamp_settling_45", 64'(settling), 64'd1);
            if (v == 46) begin
                chk("clamp_settling_46", 64'(settling), 64'd0);
                chk("clamp_addr_46", 64'(addr_out), 64'd31);
                chk("clamp_av_46", 64'(addr_valid), 64'd1);
            end
        end

        // Tap change while settling restarts the count.
        push(49, 3);
        for (int v = 50; v <= 58; v++) begin
            push(v, 7);
            if (v == 57) chk("restart_settling_57", 64'(settling), 64'd1);
            if (v == 58) begin
                chk("restart_settling_58", 64'(settling), 64'd0);
                chk("restart_addr_58", 64'(addr_out), 64'd51);
            end
        end

        // Stalled tap request is not taken.
        en = 1'b0; addr_tap = SEL_W'(2);
        repeat (2) cyc();
        chk("stall_tap_addr", 64'(addr_out), 64'd51);

        // Flush on the same edge as a tap change.
        en = 1'b1; flush = 1'b1; din_valid = 1'b0; addr_tap = SEL_W'(2);
        cyc();
        flush = 1'b0;
        chk("fltap_settling", 64'(settling), 64'd0);
        chk("fltap_addr", 64'(addr_out), 64'd56);
        chk("fltap_av", 64'(addr_valid), 64'd0);
        for (int v = 59; v <= 61; v++) begin
            push(v, 2);
            if (v == 60) chk("fltap_av_60", 64'(addr_valid), 64'd0);
            if (v == 61) begin
                chk("fltap_av_61", 64'(addr_valid), 64'd1);
                chk("fltap_addr_61", 64'(addr_out), 64'd59);
            end
        end

        // Flush while stalled.
        en = 1'b0; flush = 1'b1;
        cyc();
        flush = 1'b0;
        chk("flstall_dv", 64'(dout_valid), 64'd0);

        // Reset mid-stream while settling.
        push(62, 9);
        push(63, 9);
        chk("pre_rst_settling", 64'(settling), 64'd1);
        reset = 1'b1; en = 1'b1; din_valid = 1'b1;
        din = DATA_W'(64); addr_in = ADDR_W'(64);
        cyc();
        reset = 1'b0;
        chk("mrst_dout", 64'(dout), 64'd0);
        chk("mrst_addr", 64'(addr_out), 64'd0);
        chk("mrst_dv", 64'(dout_valid), 64'd0);
        chk("mrst_av", 64'(addr_valid), 64'd0);
        chk("mrst_settling", 64'(settling), 64'd0);

        // Tap 0 after reset: no settling, one-edge address latency.
        for (int v = 65; v <= 70; v++) begin
            push(v, 0);
            if (v == 65) begin
                chk("t0_addr_65", 64'(addr_out), 64'd65);
                chk("t0_av_65", 64'(addr_valid), 64'd1);
            end
            if (v == 66) chk("t0_dout_66", 64'(dout), 64'd65);
        end

        en = 1'b0; din_valid = 1'b0;
        repeat (2) cyc();
        chk_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
